// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the unified-RAM arbiter:
//   word_t      - 32-bit data/address word
//   ramstate_t  - status reported by the RAM model each cycle
//   arb_state_t - arbiter grant state
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, data port and RAM port of the arbiter.
//   arb modport : the arbiter side (requests and RAM status in, strobes/replies out)
//   tb  modport : the environment side (requesters plus RAM model)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // instruction fetch port
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // data memory port
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ramerr;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-ported unified RAM between instruction fetch and data
// memory. One requester is granted at a time; the granted address (and write
// data) is latched and held for the RAM's multi-cycle latency. Data has
// priority over fetch.
//
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - mem_arbiter_if.arb: fetch port, data port, RAM port
//
// Parameter:
//   STARVE_LIMIT - consecutive data grants tolerated while fetch waits (1..15)
//
// Build option:
//   MEM_ARB_FAIRNESS_EN - when defined, a streak counter lets a waiting fetch
//   win after STARVE_LIMIT back-to-back data grants. Undefined: strict data
//   priority and STARVE_LIMIT is unused.
//
// state  | meaning
// IDLE   | no grant; arbitration happens here (one turnaround cycle after each access)
// IGRANT | fetch owns the RAM, read strobe held until ACCESS/ERROR
// DGRANT | data port owns the RAM, read or write strobe held until ACCESS/ERROR
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    mem_arbiter_if.arb bus
);

    arb_state_t state, next_state;
    word_t      addr_q;
    word_t      store_q;
    logic       wr_q;
    logic       ramerr_q;
    logic       data_req;
    logic       done;
    logic       fetch_due;
    logic       enter_i;
    logic       enter_d;

    assign data_req = bus.dREN | bus.dWEN;
    assign done     = (state != IDLE) &&
                      ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR));
    assign enter_i  = (state == IDLE) && (next_state == IGRANT);
    assign enter_d  = (state == IDLE) && (next_state == DGRANT);

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] dstreak;

    // Fetch overrides data only once the data streak has reached the limit.
    assign fetch_due = bus.iREN && (dstreak == 4'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= 4'd0;
        end else if (enter_i) begin
            dstreak <= 4'd0;
        end else if (enter_d) begin
            dstreak <= bus.iREN ? dstreak + 4'd1 : 4'd0;
        end
    end
`else
    logic [3:0] unused_limit;

    assign fetch_due    = 1'b0;
    assign unused_limit = 4'(STARVE_LIMIT);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        case (state)
            IDLE: begin
                if (data_req && !fetch_due) begin
                    next_state = DGRANT;
                end else if (bus.iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                if (done) begin
                    next_state = IDLE;
                    bus.iwait  = 1'b0;
                    bus.iload  = bus.ramload;
                end
            end
            DGRANT: begin
                bus.ramWEN   = wr_q;
                bus.ramREN   = ~wr_q;
                bus.ramaddr  = addr_q;
                bus.ramstore = store_q;
                if (done) begin
                    next_state = IDLE;
                    bus.dwait  = 1'b0;
                    bus.dload  = bus.ramload;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latches; dWEN wins when both data strobes are high.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else if (enter_i) begin
            addr_q <= bus.iaddr;
        end else if (enter_d) begin
            addr_q <= bus.daddr;
            wr_q   <= bus.dWEN;
            if (bus.dWEN) begin
                store_q <= bus.dstore;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ramerr_q <= 1'b0;
        end else if (done && (bus.ramstate == ERROR)) begin
            ramerr_q <= 1'b1;
        end
    end

    assign bus.ramerr = ramerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        word_t data;
        logic  err;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    int    n_vec      = 0;
    int    n_miss     = 0;
    int    forced_lat = -1;
    bit    err_model  = 1'b0;
    exp_t  iq[$];
    exp_t  dq[$];
    word_t ram_mem[word_t];
    word_t dmem_model[word_t];

    function automatic word_t img(input word_t a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic is_err(input word_t a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic word_t bad(input word_t a);
        return 32'hBAD0_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // RAM model: BUSY/FREE for the chosen latency, then ACCESS or ERROR.
    initial begin : ram_model
        bit    active;
        int    left;
        word_t acc_addr;
        logic  acc_wr;
        word_t acc_store;
        active       = 1'b0;
        left         = 0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            tick();
            if (!nrst || !(bus.ramREN || bus.ramWEN)) begin
                active       = 1'b0;
                bus.ramstate = FREE;
                bus.ramload  = '0;
            end else begin
                if (!active) begin
                    active    = 1'b1;
                    left      = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
                    acc_addr  = bus.ramaddr;
                    acc_wr    = bus.ramWEN;
                    acc_store = bus.ramstore;
                end else begin
                    check("ram_hold", {bus.ramaddr[30:0], bus.ramWEN},
                          {acc_addr[30:0], acc_wr});
                end
                if (left > 0) begin
                    left--;
                    bus.ramstate = ($urandom_range(0, 1) != 0) ? BUSY : FREE;
                    bus.ramload  = '0;
                end else begin
                    active = 1'b0;
                    if (is_err(acc_addr)) begin
                        bus.ramstate = ERROR;
                        bus.ramload  = bad(acc_addr);
                    end else if (acc_wr) begin
                        bus.ramstate      = ACCESS;
                        bus.ramload       = '0;
                        ram_mem[acc_addr] = acc_store;
                    end else begin
                        bus.ramstate = ACCESS;
                        bus.ramload  = ram_mem.exists(acc_addr) ? ram_mem[acc_addr] : img(acc_addr);
                    end
                end
            end
        end
    end

    // Scoreboard monitor: pops an expectation whenever a wait goes low.
    initial begin : monitor
        exp_t e;
        forever begin
            smp();
            if (!nrst) begin
                err_model = 1'b0;
            end else begin
                if (!bus.iwait && !bus.dwait) begin
                    check("dual_completion", 32'd1, 32'd0);
                end
                if (!bus.iwait) begin
                    if (iq.size() == 0) begin
                        check("iwait_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = iq.pop_front();
                        check("iload", bus.iload, e.data);
                        check("ramerr_at_i", {31'b0, bus.ramerr}, {31'b0, err_model});
                        err_model = err_model | e.err;
                    end
                end else begin
                    check("iload_idle", bus.iload, 32'd0);
                end
                if (!bus.dwait) begin
                    if (dq.size() == 0) begin
                        check("dwait_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = dq.pop_front();
                        check("dload", bus.dload, e.data);
                        check("ramerr_at_d", {31'b0, bus.ramerr}, {31'b0, err_model});
                        err_model = err_model | e.err;
                    end
                end else begin
                    check("dload_idle", bus.dload, 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        n_miss++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    task automatic wait_i(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            smp();
            if (!bus.iwait) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_d(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            smp();
            if (!bus.dwait) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin : main
        exp_t       e;
        logic [1:0] fetch_exp [5];
        logic       exp_order [6];
        logic       got_order [6];
        int         g;
        bit         ok;
        word_t      a;

        bus.iREN = 0; bus.iaddr = '0;
        bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;

        // reset state, then idle with no requests
        repeat (3) tick();
        smp();
        check("in_reset", {27'b0, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramerr},
              32'b00110);
        tick();
        nrst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            smp();
            check("reset_idle", {27'b0, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramerr},
                  32'b00110);
        end

        // fetch with two BUSY cycles
        ram_mem[32'h40] = 32'h2408_0001;
        forced_lat = 2;
        fetch_exp = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b01};
        tick();
        bus.iREN = 1; bus.iaddr = 32'h40;
        e.data = 32'h2408_0001; e.err = 1'b0; iq.push_back(e);
        for (int c = 0; c < 5; c++) begin
            smp();
            check($sformatf("fetch_c%0d", c), {30'b0, bus.ramREN, bus.iwait}, {30'b0, fetch_exp[c]});
            if (c == 1) check("fetch_addr", bus.ramaddr, 32'h40);
            tick();
            if (c == 3) bus.iREN = 0;
        end

        // simultaneous fetch and write: data first, fetch after turnaround
        forced_lat = 0;
        bus.iREN = 1; bus.iaddr = 32'h80;
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        e.data = 32'h0; e.err = 1'b0; dq.push_back(e);
        e.data = img(32'h80); iq.push_back(e);
        dmem_model[32'h100] = 32'hDEAD_BEEF;
        tick(); smp();
        check("prio_strobes", {30'b0, bus.ramREN, bus.ramWEN}, 32'b01);
        check("prio_addr", bus.ramaddr, 32'h100);
        check("prio_store", bus.ramstore, 32'hDEAD_BEEF);
        check("prio_dwait", {31'b0, bus.dwait}, 32'd0);
        tick(); bus.dWEN = 0; smp();
        check("turnaround", {30'b0, bus.ramREN, bus.ramWEN}, 32'b00);
        tick(); smp();
        check("fetch_after", {30'b0, bus.ramREN, bus.iwait}, 32'b10);
        check("fetch_after_addr", bus.ramaddr, 32'h80);
        tick(); bus.iREN = 0; smp();
        check("after_idle", {30'b0, bus.ramREN, bus.ramWEN}, 32'b00);

        // continuous dREN + iREN: grant order
`ifdef MEM_ARB_FAIRNESS_EN
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 6; k++) begin
            if (exp_order[k]) begin
                e.data = img(32'h300); e.err = 1'b0; iq.push_back(e);
            end else begin
                e.data = img(32'h200); e.err = 1'b0; dq.push_back(e);
            end
            got_order[k] = 1'b0;
        end
        tick();
        bus.iREN = 1; bus.iaddr = 32'h300;
        bus.dREN = 1; bus.daddr = 32'h200;
        g = 0;
        for (int c = 1; c <= 11; c++) begin
            tick(); smp();
            if (bus.ramREN || bus.ramWEN) begin
                if (g < 6) got_order[g] = (bus.ramaddr == 32'h300);
                g++;
            end
        end
        tick();
        bus.iREN = 0; bus.dREN = 0;
        check("grant_count", g, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("grant_%0d_is_fetch", k), {31'b0, got_order[k]}, {31'b0, exp_order[k]});
        end

        // ERROR completion on a data read, sticky ramerr
        forced_lat = 1;
        tick();
        bus.dREN = 1; bus.daddr = 32'hE000_0010;
        e.data = bad(32'hE000_0010); e.err = 1'b1; dq.push_back(e);
        tick(); smp();
        check("err_c1_dwait", {31'b0, bus.dwait}, 32'd1);
        tick(); smp();
        check("err_c2_dwait", {31'b0, bus.dwait}, 32'd0);
        tick(); bus.dREN = 0; smp();
        check("err_c3_dwait", {31'b0, bus.dwait}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("ramerr_sticky", {31'b0, bus.ramerr}, 32'd1);
            tick(); smp();
        end

        // reset in the middle of a BUSY data grant
        forced_lat = 5;
        tick();
        bus.dREN = 1; bus.daddr = 32'h204;
        tick(); smp();
        check("rst_pre_strobe", {30'b0, bus.ramREN, bus.ramWEN}, 32'b10);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        check("rst_strobes_drop", {29'b0, bus.ramREN, bus.ramWEN, bus.dwait}, 32'b001);
        bus.dREN = 0;
        repeat (2) tick();
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp();
            check("rst_after", {28'b0, bus.ramREN, bus.ramWEN, bus.dwait, bus.ramerr}, 32'b0010);
            tick();
        end

        // randomized traffic on both ports
        forced_lat = -1;
        fork
            begin : fetch_drv
                exp_t  fe;
                word_t fa;
                bit    fok;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    fa = 32'h0800_0000 + 32'(4 * $urandom_range(0, 63));
                    fe.data = img(fa); fe.err = 1'b0;
                    iq.push_back(fe);
                    bus.iaddr = fa;
                    bus.iREN  = 1;
                    wait_i(fok);
                    if (!fok) check("fetch_timeout", 32'd1, 32'd0);
                    tick();
                    bus.iREN = 0;
                end
            end
            begin : data_drv
                exp_t  de;
                word_t da;
                word_t ds;
                int    kind;
                bit    dok;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(1, 3)) tick();
                    kind = $urandom_range(0, 9);
                    da = ($urandom_range(0, 9) == 0)
                         ? 32'hE000_0000 + 32'(4 * $urandom_range(0, 7))
                         : 32'h0000_1000 + 32'(4 * $urandom_range(0, 7));
                    ds = $urandom();
                    de.err = is_err(da);
                    if (kind < 4) begin
                        bus.dREN = (kind == 0);
                        bus.dWEN = 1;
                        de.data  = is_err(da) ? bad(da) : 32'h0;
                        if (!is_err(da)) dmem_model[da] = ds;
                    end else begin
                        bus.dREN = 1;
                        bus.dWEN = 0;
                        de.data  = is_err(da) ? bad(da)
                                 : (dmem_model.exists(da) ? dmem_model[da] : img(da));
                    end
                    dq.push_back(de);
                    bus.daddr  = da;
                    bus.dstore = ds;
                    wait_d(dok);
                    if (!dok) check("data_timeout", 32'd1, 32'd0);
                    tick();
                    bus.dREN = 0;
                    bus.dWEN = 0;
                end
            end
        join

        repeat (5) tick();
        check("iq_drain", iq.size(), 32'd0);
        check("dq_drain", dq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
